// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_subtractor_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout set when the bit borrows.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a-b, LSB first, one bit per clock; result registered with
// unsigned borrow and signed overflow flags.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  state_t           next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_r;
  logic             borrow_r;
  logic             overflow_r;
  logic [CW-1:0]    cnt;
  logic             d_bit;
  logic             bout_bit;
  logic             last_bit;

  full_subtractor u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (borrow_r),
    .d    (d_bit),
    .bout (bout_bit)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:    if (start) next = SHIFT;
      SHIFT:   if (last_bit) next = DONE;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // On the last bit the operand LSBs are the original MSBs, so overflow
  // is formed from them and the diff MSB being produced on this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr       <= '0;
      b_sr       <= '0;
      diff_r     <= '0;
      borrow_r   <= 1'b0;
      overflow_r <= 1'b0;
      cnt        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sr       <= a;
            b_sr       <= b;
            borrow_r   <= 1'b0;
            overflow_r <= 1'b0;
            cnt        <= '0;
          end
        end
        SHIFT: begin
          diff_r   <= {d_bit, diff_r[WIDTH-1:1]};
          a_sr     <= a_sr >> 1;
          b_sr     <= b_sr >> 1;
          borrow_r <= bout_bit;
          cnt      <= cnt + CW'(1);
          if (last_bit) begin
            overflow_r <= (a_sr[0] ^ b_sr[0]) & (d_bit ^ a_sr[0]);
          end
        end
        default: ;
      endcase
    end
  end

  assign diff     = diff_r;
  assign borrow   = borrow_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized self-checking bench for serial_subtractor against an arithmetic model.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic         overflow;

  int n_cmp;
  int n_bad;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .borrow   (borrow),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain modular, unsigned and signed arithmetic.
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] d, output logic bo, output logic ov);
    int sx;
    int sy;
    int r;
    d  = x - y;
    bo = (x < y);
    sx = int'(x);
    sy = int'(y);
    if (x[W-1]) sx = sx - (1 << W);
    if (y[W-1]) sy = sy - (1 << W);
    r  = sx - sy;
    ov = (r < -(1 << (W - 1))) || (r > (1 << (W - 1)) - 1);
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the first IDLE
  // cycle after done. With poke set, start is re-pulsed during SHIFT and DONE.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit poke);
    logic [W-1:0] ed;
    logic         eb;
    logic         eo;
    int           cyc;
    model(x, y, ed, eb, eo);
    a = x;
    b = y;
    start = 1'b1;
    @(negedge clk);
    cyc = 1;
    start = poke;
    a = W'($urandom);
    b = W'($urandom);
    while (!done && cyc < 3 * W) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
    end
    check("done_seen", int'(done), 1);
    check("latency", cyc, W + 1);
    check("busy_done", int'(busy), 1);
    check("diff", int'(diff), int'(ed));
    check("borrow", int'(borrow), int'(eb));
    check("overflow", int'(overflow), int'(eo));
    if (poke) begin
      start = 1'b1;
      a = W'($urandom);
      b = W'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    check("done_pulse", int'(done), 0);
    check("idle_busy", int'(busy), 0);
    if (poke) begin
      check("hold_diff", int'(diff), int'(ed));
      check("hold_borrow", int'(borrow), int'(eb));
    end
  endtask

  initial begin
    int dones;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_diff", int'(diff), 0);
    check("rst_borrow", int'(borrow), 0);
    check("rst_overflow", int'(overflow), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(4'b0101, 4'b0011, 1'b0);
    run_op(4'b0011, 4'b0101, 1'b0);
    run_op(4'b1111, 4'b1111, 1'b0);
    run_op(4'b1000, 4'b0001, 1'b0);
    run_op(4'b0111, 4'b1000, 1'b0);
    run_op(4'b0110, 4'b1011, 1'b1);

    // Abort two bits into SHIFT with an asynchronous reset.
    a = 4'b0110;
    b = 4'b0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_diff", int'(diff), 0);
    check("abort_borrow", int'(borrow), 0);
    check("abort_overflow", int'(overflow), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 3) rst_n = 1'b1;
      if (done) dones++;
    end
    check("abort_no_done", dones, 0);
    run_op(4'b0000, 4'b0000, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom), W'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL provide parameter: WIDTH, 4, operand/result width in bits (legal values 2..16).
REQ-002 SHALL provide port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL provide port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port: start  input  1  request to begin a subtraction, sampled on the clk edge.
REQ-005 SHALL provide port: a  input  WIDTH  minuend, unsigned or two's-complement.
REQ-006 SHALL provide port: b  input  WIDTH  subtrahend.
REQ-007 SHALL provide port: busy  output  1  high while an operation is in progress or completing.
REQ-008 SHALL provide port: done  output  1  one-cycle pulse when the result is valid.
REQ-009 SHALL provide port: diff  output  WIDTH  result a-b, modulo 2^WIDTH.
REQ-010 SHALL provide port: borrow  output  1  unsigned borrow-out, set when a < b.
REQ-011 SHALL provide port: overflow  output  1  signed overflow of a-b.
REQ-012 One clock; reset is asynchronous and active-low.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-014 IDLE: when start=1 at an edge, SHALL capture a and b into operand shift registers, clear the borrow flop and the bit counter, and go to SHIFT.
REQ-015 SHIFT: each edge SHALL process one bit, LSB first: d = a0 ^ b0 ^ bin; bout = (~a0 & b0) | (~(a0 ^ b0) & bin).
REQ-016 SHIFT SHALL shift d into the MSB of the diff register (right shift), shift both operands right, and store bout in the borrow flop.
REQ-017 The bit counter SHALL count 0..WIDTH-1; the edge that processes bit WIDTH-1 SHALL move the FSM to DONE.
REQ-018 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-019 Latency: start sampled at edge k, the bits are processed at edges k+1..k+WIDTH, and done=1 in the cycle after edge k+WIDTH.
REQ-020 done SHALL equal (state==DONE); busy SHALL equal (state!=IDLE).
REQ-021 diff, borrow and overflow SHALL be registered, become final at edge k+WIDTH, and hold until the next accepted start.
REQ-022 overflow SHALL be (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the captured operands.
REQ-023 start while busy=1 (SHIFT or DONE) SHALL be ignored; no queueing.
REQ-024 a and b changing after capture SHALL NOT affect the result.
REQ-025 During SHIFT, diff SHALL show partial shift contents; consumers sample only on done.

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE and clear busy, done, diff, borrow, overflow, the counter and the operand registers, independent of clk.
REQ-027 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse; the first start after release SHALL behave as in REQ-014.

Structure
REQ-028 Package serial_subtractor_pkg SHALL hold the FSM state enum typedef and the default-width constant (4).
REQ-029 The per-bit logic SHALL be sub-module full_subtractor (inputs a, b, bin; outputs d, bout; combinational).
REQ-030 The top level SHALL hold the FSM, counter, shift registers and the borrow/overflow registers; the implementation SHALL be 120-400 lines of RTL.

Verification (WIDTH=4)
REQ-031 a=0101, b=0011, start pulse -> done after 5 cycles; diff=0010, borrow=0, overflow=0.
REQ-032 a=0011, b=0101 -> diff=1110, borrow=1, overflow=0; a=1111, b=1111 -> diff=0000, borrow=0.
REQ-033 a=1000, b=0001 (-8-1) -> diff=0111, borrow=0, overflow=1; a=0111, b=1000 -> diff=1111, borrow=1, overflow=1.
REQ-034 Start, then start re-pulsed with different a/b during SHIFT and in the DONE cycle -> exactly one done, with the result of the first operands.
REQ-035 rst_n pulled low after 2 SHIFT cycles -> outputs zero at once and no done pulse; a fresh start with 0000-0000 -> diff=0000, borrow=0.
REQ-036 Back-to-back operations: start asserted in the first IDLE cycle after done -> second result is correct with no stale borrow.
